// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = A - B - borrow_in over WIDTH clocks.
// Optional macro SERIAL_SUB_OVERFLOW_EN adds a registered signed-overflow output.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             d_bit, borrow_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        last_bit = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_d  = IDLE;
                    last_bit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One full-subtractor cell shared across all bit positions
    always_comb begin
        d_bit      = a_sr[0] ^ b_sr[0] ^ borrow_q;
        borrow_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            diff_sr    <= '0;
            borrow_q   <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            done       <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state_q == IDLE && start) begin
                a_sr     <= A;
                b_sr     <= B;
                borrow_q <= borrow_in;
                cnt      <= '0;
                diff_sr  <= '0;
            end else if (state_q == SHIFT) begin
                a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
                diff_sr  <= {d_bit, diff_sr[WIDTH-1:1]};
                borrow_q <= borrow_nxt;
                cnt      <= cnt + 1'b1;
                // Visible result only moves on the final bit so diff stays stable mid-operation
                if (last_bit) begin
                    diff       <= {d_bit, diff_sr[WIDTH-1:1]};
                    borrow_out <= borrow_nxt;
                    done       <= 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    overflow   <= borrow_q ^ borrow_nxt;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8); overflow checked when
// SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A, B;
    logic         borrow_in;
    logic         busy, done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         overflow;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .borrow_in (borrow_in),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and pulse start across one edge (the accepting edge E)
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        A = a; B = b; borrow_in = bin; start = 1'b1;
        tick();
        start = 1'b0;
        A = $urandom; B = $urandom; borrow_in = $urandom;
    endtask

    // Called right after edge E; returns edges taken until done (or 0 on timeout).
    // inject_at >= 0 pulses start with A=0xFF after that many edges.
    task automatic wait_done(input int inject_at, output int lat);
        logic [W-1:0] held;
        logic         moved;
        held  = diff;
        moved = 1'b0;
        lat   = 0;
        chk("busy_after_start", busy, 1);
        for (int n = 1; n <= 20; n++) begin
            if (n - 1 == inject_at && inject_at >= 0) begin
                A = 8'hFF; B = 8'h00; start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            if (diff !== held) moved = 1'b1;
        end
        chk("diff_held_during_shift", moved, 0);
        chk("latency", lat, W);
        chk("busy_low_on_done", busy, 0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] exp_d, input logic exp_bo, input logic exp_ov);
        int lat;
        launch(a, b, bin);
        wait_done(-1, lat);
        chk("diff", diff, exp_d);
        chk("borrow_out", borrow_out, exp_bo);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("overflow", overflow, exp_ov);
`else
        if (exp_ov === 1'bx) chk("overflow_unused", exp_ov, 0);
`endif
        tick();
        chk("done_one_cycle", done, 0);
        chk("diff_hold_after_done", diff, exp_d);
    endtask

    initial begin
        int  lat;
        logic saw_done;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; borrow_in = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("rst_overflow", overflow, 0);
`endif
        rst = 1'b0;
        tick();

        run_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op(8'h03, 8'h05, 1'b1, 8'hFD, 1'b1, 1'b0);

        // start while busy must be ignored
        launch(8'h01, 8'h01, 1'b0);
        wait_done(3, lat);
        chk("ignored_start_diff", diff, 8'h00);
        chk("ignored_start_borrow", borrow_out, 0);
        tick();
        chk("ignored_start_idle", busy, 0);

        // back-to-back start in the done cycle
        launch(8'h5A, 8'h23, 1'b0);
        wait_done(-1, lat);
        chk("b2b_first_diff", diff, 8'h37);
        launch(8'h09, 8'h04, 1'b0);
        chk("b2b_prev_held", diff, 8'h37);
        chk("b2b_done_cleared", done, 0);
        wait_done(-1, lat);
        chk("b2b_second_diff", diff, 8'h05);
        chk("b2b_second_borrow", borrow_out, 0);
        tick();

        // reset mid-operation aborts with no done pulse
        launch(8'h10, 8'h20, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow_out, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 0);

        // rst wins over start on the same edge
        A = 8'h44; B = 8'h11; borrow_in = 1'b0; start = 1'b1; rst = 1'b1;
        tick();
        start = 1'b0; rst = 1'b0;
        chk("rst_over_start", busy, 0);

        run_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
